// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage that sits directly upstream of the IF/ID register.
// It holds the PC and chooses the next PC from PC+4, the branch target or the
// jump target. It drives a variable-latency request/ready instruction memory.
// When no valid instruction is available it presents a NOP bubble (32'h0).
//
// Optional feature macro: IF_MISALIGN_CHECK_EN
//   Defined   : a redirect target with target[1:0] != 0 is replaced by
//               EXC_VECTOR. Misalign_IF pulses for one cycle in the cycle
//               after the faulting redirect.
//   Undefined : the low two bits of the target are forced to zero, and there
//               is no Misalign_IF port.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   PCWrite        in   1 = pipeline may advance, 0 = hazard stall
//   Branch_Taken   in   branch resolved taken this cycle
//   Branch_Target  in   [31:0] branch destination
//   Jump           in   jump/jr resolved this cycle (wins over a branch)
//   Jump_Target    in   [31:0] jump destination
//   IMem_Req       out  fetch request
//   IMem_Addr      out  [31:0] fetch address, stable while a request waits
//   IMem_Ready     in   IMem_Data valid this cycle; completes the request
//   IMem_Data      in   [31:0] fetched instruction word
//   PC_IF          out  [31:0] PC of the instruction presented to IF/ID
//   Instruction_IF out  [31:0] instruction to IF/ID; 32'h0 = bubble
//   IF_Flush       out  squash the IF/ID contents (equals the redirect)
//   Fetch_Stall    out  1 = no valid instruction this cycle
//   Misalign_IF    out  one-cycle misaligned-target pulse (macro only)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000
`ifdef IF_MISALIGN_CHECK_EN
  ,parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic        Jump,
   input  logic [31:0] Jump_Target,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Ready,
   input  logic [31:0] IMem_Data,
   output logic [31:0] PC_IF,
   output logic [31:0] Instruction_IF,
   output logic        IF_Flush,
   output logic        Fetch_Stall
`ifdef IF_MISALIGN_CHECK_EN
  ,output logic        Misalign_IF
`endif
);

   // FETCH: request outstanding at PC.
   // HOLD : word captured during a stall; memory is idle.
   // DRAIN: redirected while a request was in flight; wait for it to finish.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_hold_instr;
   logic [31:0] r_pend_target;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_hold_nxt;
   logic [31:0] w_pend_nxt;

   logic        w_redirect;
   logic [31:0] w_raw_target;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;

   assign w_redirect   = Jump | Branch_Taken;
   assign w_raw_target = Jump ? Jump_Target : Branch_Target;
   // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
   assign w_pc_plus4   = r_pc + 32'd4;

`ifdef IF_MISALIGN_CHECK_EN
   logic w_misalign;
   logic r_misalign;

   assign w_misalign  = w_redirect && (w_raw_target[1:0] != 2'b00);
   assign w_target    = w_misalign ? EXC_VECTOR : w_raw_target;
   assign Misalign_IF = r_misalign;
`else
   assign w_target    = w_raw_target & 32'hFFFF_FFFC;
`endif

   // The address is always the architectural PC. A redirect while a request
   // is in flight parks the target in r_pend_target. It does not move r_pc,
   // so the address stays stable until the memory answers.
   assign IMem_Addr = r_pc;
   assign PC_IF     = reset ? RESET_PC : r_pc;
   assign IF_Flush  = reset ? 1'b0 : w_redirect;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_hold_nxt     = r_hold_instr;
      w_pend_nxt     = r_pend_target;
      IMem_Req       = 1'b0;
      Instruction_IF = 32'h0;
      Fetch_Stall    = 1'b1;

      case (r_state)
         ST_FETCH: begin
            IMem_Req = 1'b1;
            if (w_redirect) begin
               if (IMem_Ready) begin
                  w_pc_nxt = w_target;  // returned word belongs to the old path
               end else begin
                  w_pend_nxt  = w_target;
                  w_state_nxt = ST_DRAIN;
               end
            end else if (IMem_Ready) begin
               Instruction_IF = IMem_Data;
               Fetch_Stall    = 1'b0;
               if (PCWrite) begin
                  w_pc_nxt = w_pc_plus4;
               end else begin
                  w_hold_nxt  = IMem_Data;
                  w_state_nxt = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            Instruction_IF = r_hold_instr;
            Fetch_Stall    = 1'b0;
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_state_nxt = ST_FETCH;
            end else if (PCWrite) begin
               w_pc_nxt    = w_pc_plus4;
               w_state_nxt = ST_FETCH;
            end
         end

         ST_DRAIN: begin
            IMem_Req = 1'b1;
            if (w_redirect) begin
               w_pend_nxt = w_target;
            end
            if (IMem_Ready) begin
               w_pc_nxt    = w_redirect ? w_target : r_pend_target;
               w_state_nxt = ST_FETCH;
            end
         end

         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase

      // Reset abandons any in-flight request.
      if (reset) begin
         IMem_Req       = 1'b0;
         Instruction_IF = 32'h0;
         Fetch_Stall    = 1'b1;
      end
   end

   // NOTE: the state register uses non-blocking assignments so every register
   // samples values from before the edge, whatever the statement order.
   // NOTE: the data registers are reset as well, so a stale word or target
   // can never reach IF/ID after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_FETCH;
         r_pc          <= RESET_PC;
         r_hold_instr  <= 32'h0;
         r_pend_target <= 32'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_hold_instr  <= w_hold_nxt;
         r_pend_target <= w_pend_nxt;
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_misalign;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit. The reference model tracks
// behaviour, not circuit structure. It keeps the architectural PC, a flag
// for "a captured word is being held", a flag for "waiting out an abandoned
// request", and the parked target. From these it predicts every output of
// the next cycle. The memory returns a word derived from the address, so the
// expected instruction comes from the model PC.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   logic        clock = 1'b0;
   logic        reset;
   logic        PCWrite;
   logic        Branch_Taken;
   logic [31:0] Branch_Target;
   logic        Jump;
   logic [31:0] Jump_Target;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Ready;
   logic [31:0] IMem_Data;
   logic [31:0] PC_IF;
   logic [31:0] Instruction_IF;
   logic        IF_Flush;
   logic        Fetch_Stall;
`ifdef IF_MISALIGN_CHECK_EN
   logic        Misalign_IF;
`endif

   pc_fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .PCWrite        (PCWrite),
      .Branch_Taken   (Branch_Taken),
      .Branch_Target  (Branch_Target),
      .Jump           (Jump),
      .Jump_Target    (Jump_Target),
      .IMem_Req       (IMem_Req),
      .IMem_Addr      (IMem_Addr),
      .IMem_Ready     (IMem_Ready),
      .IMem_Data      (IMem_Data),
      .PC_IF          (PC_IF),
      .Instruction_IF (Instruction_IF),
      .IF_Flush       (IF_Flush),
      .Fetch_Stall    (Fetch_Stall)
`ifdef IF_MISALIGN_CHECK_EN
     ,.Misalign_IF    (Misalign_IF)
`endif
   );

   always #5 clock = ~clock;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic [31:0] m_pend;
   logic [31:0] m_word;
   logic        m_holding;
   logic        m_draining;
   logic        m_mis;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic pcw,
                       input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic rdy);
      logic        redir;
      logic [31:0] raw;
      logic [31:0] tgt;
      logic        mis;
      @(negedge clock);
      reset         = rst;
      PCWrite       = pcw;
      Branch_Taken  = br;
      Branch_Target = bt;
      Jump          = j;
      Jump_Target   = jt;
      IMem_Ready    = rdy;
      IMem_Data     = mem_word(IMem_Addr);
      #1;

      redir = j | br;
      raw   = j ? jt : bt;
`ifdef IF_MISALIGN_CHECK_EN
      mis   = redir && (raw % 4 != 0);
      tgt   = mis ? EXC_VECTOR : raw;
`else
      mis   = 1'b0;
      tgt   = raw - (raw % 4);
`endif

      // ---- predicted outputs for this cycle ----
      if (rst) begin
         check("pc_if_rst", PC_IF, RESET_PC);
         check("req_rst",   IMem_Req, 0);
         check("flush_rst", IF_Flush, 0);
         check("instr_rst", Instruction_IF, 0);
         check("stall_rst", Fetch_Stall, 1);
      end else begin
         check("pc_if", PC_IF, m_pc);
         check("flush", IF_Flush, redir);
         if (m_holding) begin
            check("req_hold",   IMem_Req, 0);
            check("instr_hold", Instruction_IF, m_word);
            check("stall_hold", Fetch_Stall, 0);
         end else if (m_draining) begin
            check("req_drain",   IMem_Req, 1);
            check("addr_drain",  IMem_Addr, m_pc);
            check("instr_drain", Instruction_IF, 0);
            check("stall_drain", Fetch_Stall, 1);
         end else begin
            check("req_fetch",  IMem_Req, 1);
            check("addr_fetch", IMem_Addr, m_pc);
            if (rdy && !redir) begin
               check("instr_fetch", Instruction_IF, mem_word(m_pc));
               check("stall_fetch", Fetch_Stall, 0);
            end else begin
               check("instr_bubble", Instruction_IF, 0);
               check("stall_bubble", Fetch_Stall, 1);
            end
         end
      end
`ifdef IF_MISALIGN_CHECK_EN
      check("misalign", Misalign_IF, m_mis);
`endif

      // ---- advance the model across the coming edge ----
      if (rst) begin
         m_pc = RESET_PC; m_pend = 0; m_word = 0;
         m_holding = 0; m_draining = 0; m_mis = 0;
      end else begin
         m_mis = mis;
         if (m_holding) begin
            if (redir)    begin m_pc = tgt;      m_holding = 0; end
            else if (pcw) begin m_pc = m_pc + 4; m_holding = 0; end
         end else if (m_draining) begin
            if (redir) m_pend = tgt;
            if (rdy) begin m_pc = m_pend; m_draining = 0; end
         end else if (redir) begin
            if (rdy) m_pc = tgt;
            else begin m_pend = tgt; m_draining = 1; end
         end else if (rdy) begin
            if (pcw) m_pc = m_pc + 4;
            else begin m_word = mem_word(m_pc); m_holding = 1; end
         end
      end
   endtask

   initial begin
      // Reset is high from time 0, so the first edge already resets the DUT.
      reset = 1; PCWrite = 0; Branch_Taken = 0; Branch_Target = 0;
      Jump = 0; Jump_Target = 0; IMem_Ready = 0; IMem_Data = 0;
      m_pc = RESET_PC; m_pend = 0; m_word = 0;
      m_holding = 0; m_draining = 0; m_mis = 0;

      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 1);

      // Zero-wait sequential fetch: 3000, 3004.
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Hazard stall at 3008 for three cycles, then resume at 300C.
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Taken branch at 3010 with ready memory.
      step(0, 1, 1, 32'h0000_3100, 0, 0, 1);
      // 3-cycle latency; jump in the first wait cycle.
      step(0, 1, 0, 0, 1, 32'h0000_3200, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Wrap from FFFF_FFFC to 0.
      step(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Misaligned branch target.
      step(0, 1, 1, 32'h0000_3102, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Jump and branch together: jump wins.
      step(0, 1, 1, 32'h0000_3300, 1, 32'h0000_3400, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Second redirect while draining overwrites the parked target.
      step(0, 1, 0, 0, 1, 32'h0000_3500, 0);
      step(0, 1, 1, 32'h0000_3600, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Redirect on the cycle the drained request completes.
      step(0, 1, 0, 0, 1, 32'h0000_3700, 0);
      step(0, 0, 1, 32'h0000_3800, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      // Reset in the middle of a request.
      step(0, 1, 0, 0, 1, 32'h0000_3900, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1);
      // Redirect while holding a captured word.
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'h0000_3A00, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 50) == 0,
              ($urandom % 4) != 0,
              ($urandom % 8) == 0, $urandom,
              ($urandom % 10) == 0, $urandom,
              ($urandom % 2) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the PC and selects the next PC from PC+4, the branch target or the jump target. Drives a variable-latency instruction-memory request/ready interface. Produces PC_IF, Instruction_IF and IF_Flush for the IF/ID register, and inserts a NOP bubble whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VECTOR, 32'h0000_4180, redirect address for a misaligned target (optional feature only)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
PCWrite  input  1  1 = pipeline may advance; 0 = hold PC and instruction (hazard stall)
Branch_Taken  input  1  branch resolved taken this cycle
Branch_Target  input  32  branch destination
Jump  input  1  jump/jr resolved this cycle
Jump_Target  input  32  jump destination
IMem_Req  output  1  fetch request
IMem_Addr  output  32  fetch address; stable while IMem_Req=1 and IMem_Ready=0
IMem_Ready  input  1  IMem_Data valid this cycle; completes the request
IMem_Data  input  32  fetched instruction word
PC_IF  output  32  PC of the instruction presented to IF/ID
Instruction_IF  output  32  instruction presented to IF/ID; 32'h0 = bubble
IF_Flush  output  1  squash the IF/ID contents
Fetch_Stall  output  1  1 = no valid instruction this cycle

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- Registers: PC (32), Hold_Instr (32), Pend_Target (32), state (2 bits).
- Reset: PC=RESET_PC, state=FETCH, Hold_Instr=0, Pend_Target=0.
- While reset is asserted: IMem_Req=0, IF_Flush=0, Instruction_IF=0, Fetch_Stall=1, PC_IF=RESET_PC.
- Reset mid-request: the in-flight request is abandoned; the memory must tolerate Req dropping.
- Redirect = Jump | Branch_Taken.
  - Target = Jump ? Jump_Target : Branch_Target (Jump wins if both).
  - Feature off: target[1:0] forced to 2'b00.
- IF_Flush = Redirect, combinational, independent of state and PCWrite.
- Next sequential PC = PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- State FETCH: IMem_Req=1, IMem_Addr=PC.
  - Redirect, Ready=1: data discarded; PC<=target; stay FETCH.
  - Redirect, Ready=0: Pend_Target<=target; go DRAIN. PC and IMem_Addr stay unchanged to honour address stability.
  - Ready=1, PCWrite=1: Instruction_IF=IMem_Data, PC_IF=PC, Fetch_Stall=0; PC<=PC+4; stay FETCH (back-to-back fetch, 1 instr/cycle with zero-wait memory).
  - Ready=1, PCWrite=0: Hold_Instr<=IMem_Data; go HOLD; PC unchanged.
  - Ready=0: Instruction_IF=0, Fetch_Stall=1.
- State HOLD: IMem_Req=0. Instruction_IF=Hold_Instr, PC_IF=PC, Fetch_Stall=0.
  - Redirect: PC<=target; go FETCH.
  - PCWrite=1: PC<=PC+4; go FETCH.
  - Otherwise: stay HOLD; no refetch.
- State DRAIN: IMem_Req=1, IMem_Addr=PC (old address). Instruction_IF=0, Fetch_Stall=1.
  - A second redirect overwrites Pend_Target.
  - Ready=1: data discarded; PC<=Pend_Target, or the new target if a redirect arrives the same cycle; go FETCH.
- Instruction_IF outside the valid cases above = 32'h0. PC_IF always = PC.
- Redirect is taken regardless of PCWrite. Priority: reset > redirect > stall.

Optional Feature:
IF_MISALIGN_CHECK_EN
- Defined:
  - A redirect target with target[1:0]!=0 uses EXC_VECTOR as the target; the same FETCH/DRAIN rules apply.
  - Adds output Misalign_IF (1 bit): registered pulse, high for one cycle in the cycle after the faulting redirect, cleared by reset.
- Undefined: no Misalign_IF port; low two bits silently forced to 0.

Test Plan:
- Reset, zero-wait memory (Ready=1), PCWrite=1 -> PC_IF sequence 3000,3004,3008; Instruction_IF = memory words; Fetch_Stall=0.
- Ready=1, PCWrite=0 for 3 cycles at PC=3008 -> PC_IF holds 3008; Instruction_IF holds the word; IMem_Req=0 after the first cycle; resumes at 300C with no refetch.
- Branch_Taken=1, target 32'h0000_3100, at PC=3010 with Ready=1 -> IF_Flush=1 that cycle; next IMem_Addr=3100.
- Memory 3-cycle latency; Jump to 32'h0000_3200 in the first wait cycle -> IMem_Addr stays at the old PC until Ready; that data is dropped (Instruction_IF=0); next IMem_Addr=3200.
- PC=32'hFFFF_FFFC, Ready=1, PCWrite=1 -> next PC_IF=0.
- With IF_MISALIGN_CHECK_EN, Branch_Target=32'h0000_3102 -> next IMem_Addr=4180; Misalign_IF high one cycle. Without the macro -> next IMem_Addr=3100.
